// File: rtl/dechuff_mcu_sched.sv
// Shares one upstream entropy-coded byte stream among NLANES Huffman decoder lanes.
// Bytes go to one lane at a time in MCU order. Each lane holds the stream for its
// configured number of blocks and hands it on when it reports end-of-block.
// An upstream end-of-stream token is fanned out to every lane in index order before
// it is consumed.
module dechuff_mcu_sched #(
    parameter int unsigned NLANES = 3,
    parameter int unsigned W      = 8,
    parameter int unsigned CW     = 3,
    parameter int unsigned MW     = 16,
    localparam int unsigned LW    = (NLANES > 1) ? $clog2(NLANES) : 1,
    localparam int unsigned PW    = $clog2(NLANES + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [W-1:0]         src_d,
    input  logic                 src_v,
    input  logic                 src_e,
    output logic                 src_b,
    output logic [W-1:0]         lane_d,
    output logic [NLANES-1:0]    lane_v,
    output logic [NLANES-1:0]    lane_e,
    input  logic [NLANES-1:0]    lane_b,
    input  logic [NLANES-1:0]    eob_v,
    output logic [NLANES-1:0]    eob_b,
    input  logic [NLANES*CW-1:0] blk_cnt,
    output logic [LW-1:0]        cur_lane,
    output logic [MW-1:0]        mcu_count,
    output logic                 busy,
    output logic                 cfg_err
);

    typedef enum logic [1:0] {StIdle, StSel, StFwd, StFlush} state_e;

    state_e        state_q;
    logic [PW-1:0] ptr_q;    // next lane to consider in SEL; NLANES means MCU done
    logic [PW-1:0] flush_q;  // lane receiving end-of-stream; NLANES means consume upstream
    logic [CW-1:0] blk_q;    // blocks finished by the granted lane in this MCU
    logic [CW-1:0] blk_inc;

    logic [CW-1:0] cnt_arr [NLANES];
    logic          sel_found;
    logic          all_zero;
    logic [LW-1:0] sel_lane;
    logic          eob_hit;
    logic          flush_tail;
    logic [LW-1:0] flush_lane;

    for (genvar g = 0; g < NLANES; g++) begin : g_cnt
        assign cnt_arr[g] = blk_cnt[g*CW +: CW];
    end

    assign blk_inc    = blk_q + CW'(1);
    assign eob_hit    = eob_v[cur_lane];
    assign flush_tail = (flush_q == PW'(NLANES));
    assign flush_lane = flush_q[LW-1:0];
    assign busy       = (state_q != StIdle);
    assign lane_d     = src_d;

    // Lowest lane at or above the pointer that owns at least one block per MCU.
    always_comb begin
        sel_found = 1'b0;
        all_zero  = 1'b1;
        sel_lane  = '0;
        for (int i = 0; i < int'(NLANES); i++) begin
            if (cnt_arr[i] != '0) begin
                all_zero = 1'b0;
                if (!sel_found && (i >= int'(ptr_q))) begin
                    sel_found = 1'b1;
                    sel_lane  = LW'(i);
                end
            end
        end
    end

    // Stream handshakes: zero-latency pass-through to the granted lane, eob first.
    always_comb begin
        src_b  = 1'b1;
        lane_v = '0;
        lane_e = '0;
        eob_b  = '1;
        case (state_q)
            StFwd: begin
                eob_b[cur_lane] = 1'b0;
                if (!eob_hit && !(src_v && src_e)) begin
                    src_b            = lane_b[cur_lane];
                    lane_v[cur_lane] = src_v;
                end
            end
            StFlush: begin
                if (flush_tail) begin
                    src_b = 1'b0;
                end else begin
                    lane_v[flush_lane] = 1'b1;
                    lane_e[flush_lane] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Scheduler state, grant, block and MCU bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            flush_q   <= '0;
            blk_q     <= '0;
            cur_lane  <= '0;
            mcu_count <= '0;
            cfg_err   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (src_v) begin
                        state_q <= StSel;
                        ptr_q   <= '0;
                    end
                end
                StSel: begin
                    if (sel_found) begin
                        cur_lane <= sel_lane;
                        blk_q    <= '0;
                        state_q  <= StFwd;
                    end else if (all_zero) begin
                        cfg_err <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        // Ran past the last active lane: MCU complete, search again from 0.
                        mcu_count <= mcu_count + MW'(1);
                        ptr_q     <= '0;
                    end
                end
                StFwd: begin
                    if (eob_hit) begin
                        blk_q <= blk_inc;
                        if (blk_inc == cnt_arr[cur_lane]) begin
                            ptr_q   <= PW'(cur_lane) + PW'(1);
                            state_q <= StSel;
                        end
                    end else if (src_v && src_e) begin
                        flush_q <= '0;
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if (flush_tail) begin
                        state_q <= StIdle;
                    end else if (!lane_b[flush_lane]) begin
                        flush_q <= flush_q + PW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dechuff_mcu_sched.sv
// Directed bench for dechuff_mcu_sched: a byte source, three lane consumers that
// raise eob after every 6th byte, and hand-computed expectations per scenario.
module tb_dechuff_mcu_sched;

    localparam int NL = 3;
    localparam int W  = 8;
    localparam int CW = 3;
    localparam int MW = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [W-1:0]     src_d;
    logic             src_v;
    logic             src_e;
    logic             src_b;
    logic [W-1:0]     lane_d;
    logic [NL-1:0]    lane_v;
    logic [NL-1:0]    lane_e;
    logic [NL-1:0]    lane_b;
    logic [NL-1:0]    eob_v;
    logic [NL-1:0]    eob_b;
    logic [NL*CW-1:0] blk_cnt;
    logic [1:0]       cur_lane;
    logic [MW-1:0]    mcu_count;
    logic             busy;
    logic             cfg_err;

    dechuff_mcu_sched #(.NLANES(NL), .W(W), .CW(CW), .MW(MW)) dut (
        .clock    (clock),
        .reset    (reset),
        .src_d    (src_d),
        .src_v    (src_v),
        .src_e    (src_e),
        .src_b    (src_b),
        .lane_d   (lane_d),
        .lane_v   (lane_v),
        .lane_e   (lane_e),
        .lane_b   (lane_b),
        .eob_v    (eob_v),
        .eob_b    (eob_b),
        .blk_cnt  (blk_cnt),
        .cur_lane (cur_lane),
        .mcu_count(mcu_count),
        .busy     (busy),
        .cfg_err  (cfg_err)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Bench-side source / consumer state.
    int       src_idx, nbytes_lim, eob_total, stalls, eos_cnt;
    int       mirror_bad, multi_bad, eobb_bad, held, cr_eob_lane, cyc, e_code;
    bit       send_eos, toggle_y, eos_done;
    logic [2:0] pending;
    int       lane_cnt [NL];
    int       e_seen [NL];
    int       rx0[$], rx1[$], rx2[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int q[$], input int first, input int n);
        int bad = 0;
        check_eq({tag, "_len"}, q.size(), n);
        foreach (q[k]) if (q[k] != first + k) bad++;
        check_eq({tag, "_order"}, bad, 0);
    endtask

    task automatic do_reset(input logic [NL*CW-1:0] cfg);
        reset   = 1'b0;
        src_v   = 1'b0;
        src_e   = 1'b0;
        src_d   = '0;
        lane_b  = '0;
        eob_v   = '0;
        blk_cnt = cfg;
        src_idx = 0; nbytes_lim = 0; eob_total = 0; stalls = 0; eos_cnt = 0;
        mirror_bad = 0; multi_bad = 0; eobb_bad = 0; held = 0; cr_eob_lane = -1;
        cyc = 0; e_code = 0; send_eos = 0; toggle_y = 0; eos_done = 0; pending = '0;
        for (int i = 0; i < NL; i++) begin
            lane_cnt[i] = 0;
            e_seen[i]   = 0;
        end
        rx0.delete(); rx1.delete(); rx2.delete();
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
    endtask

    // One clock: drive just after the edge, sample mid-cycle.
    task automatic step();
        @(posedge clock);
        #1;
        src_e  = send_eos && (src_idx >= nbytes_lim);
        src_v  = (src_idx < nbytes_lim) || (src_e && !eos_done);
        src_d  = W'(src_idx);
        eob_v  = pending;
        lane_b = '0;
        if (toggle_y) lane_b[0] = cyc[0];
        if (src_e) for (int i = 0; i < NL; i++) lane_b[i] = (e_seen[i] < 2);
        #3;
        cyc++;
        if (src_v && src_b) stalls++;
        if (src_v && !src_b) begin
            if (src_e) begin
                eos_cnt++;
                eos_done = 1'b1;
            end else begin
                src_idx++;
            end
        end
        if ($countones(lane_v) > 1) multi_bad++;
        if (lane_v[0] && (src_b != lane_b[0])) mirror_bad++;
        if (cur_lane == 2'd0 && eob_v[2] && eob_b[2]) held++;
        for (int i = 0; i < NL; i++) begin
            if (lane_e[i]) e_seen[i]++;
            if (lane_v[i] && !lane_b[i]) begin
                if (lane_e[i]) begin
                    e_code = e_code * 10 + i + 1;
                end else begin
                    case (i)
                        0:       rx0.push_back(int'(lane_d));
                        1:       rx1.push_back(int'(lane_d));
                        default: rx2.push_back(int'(lane_d));
                    endcase
                    lane_cnt[i]++;
                    if (lane_cnt[i] == 6) begin
                        lane_cnt[i] = 0;
                        pending[i]  = 1'b1;
                    end
                end
            end
            if (!eob_b[i] && int'(cur_lane) != i) eobb_bad++;
            if (eob_v[i] && !eob_b[i]) begin
                pending[i] = 1'b0;
                eob_total++;
                if (i == 2) cr_eob_lane = int'(cur_lane);
            end
        end
    endtask

    task automatic run(input int nb, input int ne, input bit eos);
        int n = 0;
        nbytes_lim = nb;
        send_eos   = eos;
        while (!(src_idx >= nb && eob_total >= ne && (!eos || eos_done)) && n < 400) begin
            step();
            n++;
        end
        check_eq("run_timeout", (n >= 400), 0);
    endtask

    task automatic settle(input int k);
        repeat (k) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_src_b"}, src_b, 1);
        check_eq({tag, "_lane_v"}, lane_v, 0);
        check_eq({tag, "_lane_e"}, lane_e, 0);
        check_eq({tag, "_eob_b"}, eob_b, 7);
        check_eq({tag, "_cur_lane"}, cur_lane, 0);
        check_eq({tag, "_mcu"}, mcu_count, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values while reset is held, with upstream offering a byte.
        src_v = 1'b1; src_e = 1'b0; src_d = 8'h5A; lane_b = '0; eob_v = '1;
        blk_cnt = 9'o114;
        #12;
        check_reset_vals("rst");

        // Y=4, Cb=1, Cr=1 blocks; 6 bytes per block, no lane stalls.
        do_reset(9'o114);
        run(36, 6, 0);
        settle(3);
        check_seq("t1_y", rx0, 0, 24);
        check_seq("t1_cb", rx1, 24, 6);
        check_seq("t1_cr", rx2, 30, 6);
        check_eq("t1_stalls", stalls, 9);
        check_eq("t1_mcu", mcu_count, 1);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_lane", cur_lane, 0);
        check_eq("t1_multi_v", multi_bad, 0);
        check_eq("t1_eob_b", eobb_bad, 0);

        // Same, with Y backpressure toggling every cycle.
        do_reset(9'o114);
        toggle_y = 1'b1;
        run(36, 6, 0);
        settle(3);
        check_seq("t2_y", rx0, 0, 24);
        check_seq("t2_cb", rx1, 24, 6);
        check_seq("t2_cr", rx2, 30, 6);
        check_eq("t2_mirror", mirror_bad, 0);
        check_eq("t2_mcu", mcu_count, 1);
        toggle_y = 1'b0;

        // Cr raises eob from the start; it must wait until Cr is granted.
        do_reset(9'o114);
        pending = 3'b100;
        run(30, 6, 0);
        settle(3);
        check_seq("t3_y", rx0, 0, 24);
        check_seq("t3_cb", rx1, 24, 6);
        check_eq("t3_cr_len", rx2.size(), 0);
        check_eq("t3_cr_eob_lane", cr_eob_lane, 2);
        check_eq("t3_cr_held", (held > 10), 1);
        check_eq("t3_eob_b", eobb_bad, 0);
        check_eq("t3_mcu", mcu_count, 1);

        // Only Cb active with 2 blocks per MCU.
        do_reset(9'o020);
        run(12, 2, 0);
        settle(3);
        check_eq("t4_mcu1", mcu_count, 1);
        run(24, 4, 0);
        settle(3);
        check_eq("t4_mcu2", mcu_count, 2);
        check_seq("t4_cb", rx1, 0, 24);
        check_eq("t4_y_len", rx0.size(), 0);
        check_eq("t4_cr_len", rx2.size(), 0);

        // End-of-stream in the middle of the second Y block.
        do_reset(9'o114);
        run(8, 1, 1);
        settle(3);
        check_seq("t5_y", rx0, 0, 8);
        check_eq("t5_e_order", e_code, 123);
        check_eq("t5_e_hold0", e_seen[0], 3);
        check_eq("t5_e_hold1", e_seen[1], 3);
        check_eq("t5_e_hold2", e_seen[2], 3);
        check_eq("t5_eos_cnt", eos_cnt, 1);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_mcu", mcu_count, 0);

        // All block counts zero.
        do_reset(9'o000);
        nbytes_lim = 1;
        repeat (4) step();
        check_eq("t6_src_b_stall", stalls, 4);
        check_eq("t6_consumed", src_idx, 0);
        check_eq("t6_cfg_err", cfg_err, 1);
        check_eq("t6_lane_v", lane_v, 0);

        // Reset asserted while forwarding to Cb in the second MCU.
        do_reset(9'o114);
        run(62, 10, 0);
        #1;
        src_v = 1'b1; src_e = 1'b0; src_d = 8'hAA; lane_b = '0; eob_v = '0;
        #1;
        check_eq("t7_pre_lane_v", lane_v, 2);
        check_eq("t7_pre_mcu", mcu_count, 1);
        check_eq("t7_pre_lane", cur_lane, 1);
        reset = 1'b0;
        #1;
        check_reset_vals("t7_rst");
        #20 reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
